instr_fetch_seq: RTL
====================

// Module: instr_fetch_seq
// PURPOSE
//  Drives the read address of the autoencoder instruction memory and consumes its registered
//  instruction word. Produces a valid/ready instruction stream with decoded opcode/operand for
//  the control datapath. Handles the memory's 1-cycle registered read latency.
//  Terminates on a HALT opcode or on address overrun.
// PARAMETERS
//  DATA_WIDTH   16  instruction word width
//  PC_WIDTH     5   address width; matches instruction-memory counter port
//  DEPTH        32  number of instruction words; last address is DEPTH-1
//  OPCODE_WIDTH 4   opcode field = instructCode[DATA_WIDTH-1 -: OPCODE_WIDTH]
// PORTS
//  clk           in   1                          rising-edge clock
//  rst_n         in   1                          synchronous reset, active-low
//  start         in   1                          1-cycle pulse; begin program at address 0
//  counter       out  PC_WIDTH                   instruction-memory read address (registered)
//  instructCode  in   DATA_WIDTH                 memory output; valid 1 cycle after counter changes
//  instr_valid   out  1                          opcode/operand valid
//  instr_ready   in   1                          consumer accepts when valid&ready
//  opcode        out  OPCODE_WIDTH               decoded opcode (registered)
//  operand       out  DATA_WIDTH-OPCODE_WIDTH    decoded operand (registered)
//  busy          out  1                          high in WAIT/LATCH/ISSUE
//  done          out  1                          1-cycle pulse at program end
//  overrun       out  1                          sticky; PC passed DEPTH-1 without HALT; cleared by start
// BEHAVIOUR
//  - Reset (rst_n=0 at a clock edge): state=IDLE; counter, opcode, operand=0; instr_valid,
//    busy, done, overrun=0. Reset mid-program abandons the program; no done pulse.
//  - States: IDLE -> WAIT -> LATCH -> ISSUE -> (WAIT | DONE) ; DONE -> IDLE.
//  - IDLE: on start: counter<=0, overrun<=0, go to WAIT. Else hold.
//  - WAIT: 1 cycle; the memory samples counter at this edge.
//  - LATCH: register instructCode into opcode/operand; go to ISSUE.
//  - ISSUE: instr_valid=1; opcode/operand held stable until handshake.
//  - ISSUE handshake (instr_valid & instr_ready):
//    - opcode==OP_HALT (4'hF): go to DONE.
//    - counter==DEPTH-1: overrun<=1, go to DONE.
//    - otherwise: counter<=counter+1, go to WAIT.
//  - DONE: done=1 for 1 cycle; go to IDLE. Counter keeps its last value.
//  - Latency/throughput: start edge to first instr_valid = 3 cycles.
//    Max rate = 1 instruction per 3 cycles.
//  - start is ignored when not IDLE. instr_ready is ignored when instr_valid=0.
//  - HALT is presented to the consumer like any other instruction: it needs a handshake before DONE.
//  - PC arithmetic is unsigned PC_WIDTH. No wrap: overrun ends the program instead.
// CONFIGURATION
//  INSTR_JUMP_EN defined:
//    - On ISSUE handshake with opcode==OP_JMP (4'hE): counter<=operand[PC_WIDTH-1:0], go to WAIT.
//    - No overrun check on JMP.
//    - A jump target >= DEPTH saturates to DEPTH-1.
//  INSTR_JUMP_EN undefined: OP_JMP is treated as an ordinary instruction (sequential advance).
// STRUCTURE
//  - Shared package autoencoder_isa_pkg:
//    - opcode constants OP_NOP=4'h0, OP_JMP=4'hE, OP_HALT=4'hF
//    - OPCODE_WIDTH
//    - fetch state encoding (IDLE/WAIT/LATCH/ISSUE/DONE)
//  - One sub-module, instr_field_decode: combinational split of instructCode into opcode/operand.
//    Its outputs are registered in this block's LATCH state.
// TESTING
//  1. Program {0x1001, 0x2002, 0xF000}, start, instr_ready=1:
//     -> counter 0,1,2; three handshakes with opcodes 1,2,F; done 1 cycle after 3rd handshake;
//        overrun=0.
//  2. Same program, instr_ready=0 for 5 cycles in 1st ISSUE:
//     -> instr_valid held, opcode=1/operand=0x001 stable, counter stays 0.
//  3. 32 NOPs, no HALT:
//     -> 32 handshakes, last at counter=31; overrun=1; done pulse.
//     -> next start clears overrun and counter=0.
//  4. rst_n=0 while in ISSUE at address 3:
//     -> next cycle all outputs 0, state IDLE, no done. A start pulse during busy is ignored.
//  5. INSTR_JUMP_EN on, program {0x1000, 0xE004, 0x2000, 0x3000, 0xF000}:
//     -> issued addresses 0,1,4; done.
//  6. INSTR_JUMP_EN off, same program:
//     -> addresses 0,1,2,3,4 issued; done.

Source files
------------

// File: rtl/autoencoder_isa_pkg.sv
// Shared ISA constants and fetch-sequencer state encoding for the autoencoder control path.
// Imported by the instruction fetch sequencer, its decoder and its bus interface.
`default_nettype none

package autoencoder_isa_pkg;

    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 4'hE;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LATCH = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_seq_if.sv
// Bus bundle of the fetch sequencer: program control, instruction-memory port and issue stream.
// master = sequencer side, slave = memory/consumer/controller side.
`default_nettype none

interface instr_fetch_seq_if
    import autoencoder_isa_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 5
);

    logic                                start;
    logic [PC_WIDTH-1:0]                 counter;
    logic [DATA_WIDTH-1:0]               instructCode;
    logic                                instr_valid;
    logic                                instr_ready;
    logic [OPCODE_WIDTH-1:0]             opcode;
    logic [DATA_WIDTH-OPCODE_WIDTH-1:0]  operand;
    logic                                busy;
    logic                                done;
    logic                                overrun;

    modport master (
        input  start, instructCode, instr_ready,
        output counter, instr_valid, opcode, operand, busy, done, overrun
    );

    modport slave (
        output start, instructCode, instr_ready,
        input  counter, instr_valid, opcode, operand, busy, done, overrun
    );

endinterface

`default_nettype wire

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into opcode (top bits) and operand (remaining bits).
`default_nettype none

module instr_field_decode
    import autoencoder_isa_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]              instr_code,
    output logic [OPCODE_WIDTH-1:0]            opcode,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand
);

    assign opcode  = instr_code[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign operand = instr_code[DATA_WIDTH-OPCODE_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: walks the instruction memory and issues decoded words on a valid/ready
// stream; ends on HALT or address overrun. Define INSTR_JUMP_EN to enable OP_JMP as an absolute jump.
`default_nettype none

module instr_fetch_seq
    import autoencoder_isa_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 5,
    parameter int DEPTH      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_seq_if.master bus
);

    localparam int                  OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH;
    localparam logic [PC_WIDTH-1:0] LAST_ADDR     = PC_WIDTH'(DEPTH - 1);

    fetch_state_t              state;
    fetch_state_t              state_next;
    logic [OPCODE_WIDTH-1:0]   dec_opcode;
    logic [OPERAND_WIDTH-1:0]  dec_operand;
    logic                      handshake;
    logic                      is_halt;
    logic                      is_jump;
    logic                      at_last;
    logic [PC_WIDTH-1:0]       jump_target;

    instr_field_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr_code (bus.instructCode),
        .opcode     (dec_opcode),
        .operand    (dec_operand)
    );

    assign handshake = (state == ST_ISSUE) && bus.instr_ready;
    assign is_halt   = (bus.opcode == OP_HALT);
    assign at_last   = (bus.counter == LAST_ADDR);

`ifdef INSTR_JUMP_EN
    // Targets beyond the last word clamp to it rather than wrapping.
    assign is_jump     = (bus.opcode == OP_JMP);
    assign jump_target = (32'(bus.operand[PC_WIDTH-1:0]) >= 32'(DEPTH)) ? LAST_ADDR
                                                                        : bus.operand[PC_WIDTH-1:0];
`else
    assign is_jump     = 1'b0;
    assign jump_target = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.start) state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_LATCH;
            ST_LATCH: state_next = ST_ISSUE;
            ST_ISSUE: begin
                if (handshake) begin
                    if (is_halt)      state_next = ST_DONE;
                    else if (is_jump) state_next = ST_WAIT;
                    else if (at_last) state_next = ST_DONE;
                    else              state_next = ST_WAIT;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state == ST_WAIT) || (state == ST_LATCH) || (state == ST_ISSUE);
        bus.instr_valid = (state == ST_ISSUE);
        bus.done        = (state == ST_DONE);
    end

    // The memory word is registered one cycle after counter settles, so it is captured in LATCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.counter <= '0;
            bus.opcode  <= '0;
            bus.operand <= '0;
            bus.overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        bus.counter <= '0;
                        bus.overrun <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    bus.opcode  <= dec_opcode;
                    bus.operand <= dec_operand;
                end
                ST_ISSUE: begin
                    if (handshake && !is_halt) begin
                        if (is_jump)      bus.counter <= jump_target;
                        else if (at_last) bus.overrun <= 1'b1;
                        else              bus.counter <= bus.counter + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
